fetch_sequencer: RTL and testbench

Owns the program counter and sequences instruction fetch over a req/ack instruction-memory handshake. It computes the next PC with the same rules as the single-cycle PC: sequential +4, taken branch, and jump. It holds each fetched instruction stable while the downstream datapath stalls. A watchdog flags a memory that never acknowledges.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/next_pc_calc.sv | 32 +++
 rtl/fetch_sequencer.sv | 130 +++++++++++++
 tb/tb_fetch_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch sequencer
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        ERR   = 2'd3
    } fetch_state_e;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam int          JUMP_HI_BITS     = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational next-PC selection: branch over jump over pc+4
module next_pc_calc
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic [15:0] br_imm,
    input  logic [25:0] j_target,
    output logic [31:0] next_pc
);

    logic [31:0] pc4;
    logic [31:0] br_dest;
    logic [31:0] j_dest;

    assign pc4     = pc + PC_INC;
    assign br_dest = pc4 + {{14{br_imm[15]}}, br_imm, 2'b00};
    // Jump keeps the region bits of the sequential PC.
    assign j_dest  = {pc4[31:32-JUMP_HI_BITS], j_target, 2'b00};

    always_comb begin
        next_pc = pc4;
        if (branch && zero) begin
            next_pc = br_dest;
        end else if (jump) begin
            next_pc = j_dest;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner and req/ack fetch FSM with watchdog
// Optional FETCH_PERF_EN adds fetch and stall performance counters.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    input  logic              stall,
    input  logic              branch,
    input  logic              zero,
    input  logic              jump,
    input  logic [15:0]       br_imm,
    input  logic [25:0]       j_target,
    output logic [ADDR_W-1:0] pc,
`ifdef FETCH_PERF_EN
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt,
`endif
    output logic              fetch_err
);

    localparam int WCNT_W = $clog2(MAX_WAIT + 1);

    fetch_state_e      state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]       next_pc;

    next_pc_calc u_next_pc (
        .pc       (pc_q),
        .branch   (branch),
        .zero     (zero),
        .jump     (jump),
        .br_imm   (br_imm),
        .j_target (j_target),
        .next_pc  (next_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    instr_d    = imem_rdata;
                    wait_cnt_d = '0;
                    state_d    = HOLD;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                    // Counter reaches MAX_WAIT on this edge: req was high MAX_WAIT cycles.
                    if (wait_cnt_q == WCNT_W'(MAX_WAIT - 1)) begin
                        state_d = ERR;
                    end
                end
            end
            HOLD: begin
                if (!stall) begin
                    pc_d    = next_pc;
                    state_d = FETCH;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode from registered state so reset drops them asynchronously.
    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == HOLD);
    assign pc          = pc_q;
    assign fetch_err   = (state_q == ERR);

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            if (state_q == FETCH && imem_ack) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (state_q == HOLD && stall) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        stall = 1'b0, branch = 1'b0, zero = 1'b0, jump = 1'b0;
    logic [15:0] br_imm = 16'd0;
    logic [25:0] j_target = 26'd0;

    logic        imem_req, instr_valid, fetch_err;
    logic [31:0] imem_addr, instr, pc;
    logic        req2, valid2, err2;
    logic [31:0] addr2, instr2, pc2;
`ifdef FETCH_PERF_EN
    logic [31:0] pf1, ps1, pf2, ps2;
`endif

    always #5 clk = ~clk;

    fetch_sequencer #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .MAX_WAIT(15)) u_dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
        .stall(stall), .branch(branch), .zero(zero), .jump(jump), .br_imm(br_imm),
        .j_target(j_target), .pc(pc),
`ifdef FETCH_PERF_EN
        .perf_fetch_cnt(pf1), .perf_stall_cnt(ps1),
`endif
        .fetch_err(fetch_err)
    );

    fetch_sequencer #(.ADDR_W(32), .RESET_PC(32'h4000_0020), .MAX_WAIT(15)) u_dut_hi (
        .clk(clk), .rst_n(rst_n), .imem_req(req2), .imem_addr(addr2),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr2), .instr_valid(valid2),
        .stall(stall), .branch(branch), .zero(zero), .jump(jump), .br_imm(br_imm),
        .j_target(j_target), .pc(pc2),
`ifdef FETCH_PERF_EN
        .perf_fetch_cnt(pf2), .perf_stall_cnt(ps2),
`endif
        .fetch_err(err2)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] cur_pc, cur_instr, nxt;
    int          exp_fetch = 0;
    int          exp_stall = 0;

    typedef struct {
        logic        br;
        logic        z;
        logic        j;
        logic [15:0] imm;
        logic [25:0] jt;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[12];

    function automatic logic [31:0] ref_next(input logic [31:0] p, input logic b, input logic z,
                                             input logic j, input logic [15:0] imm,
                                             input logic [25:0] jt);
        logic [31:0] seq;
        int          off;
        seq = p + 32'd4;
        off = $signed(imm);
        if (b && z) return seq + 32'(off * 4);
        if (j) return (seq & 32'hF000_0000) | (32'(jt) * 32'd4);
        return seq;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_err", 32'(fetch_err), 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        chk("idle_req", 32'(imem_req), 32'd0);
        exp_fetch = 0;
        exp_stall = 0;
    endtask

    task automatic do_fetch(input int delay, input logic [31:0] exp_addr, input logic [31:0] word);
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("req_seen", 32'(imem_req), 32'd1);
        chk("fetch_addr", imem_addr, exp_addr);
        for (int k = 0; k < delay; k++) begin
            step();
            chk("req_held", 32'(imem_req), 32'd1);
            chk("addr_held", imem_addr, exp_addr);
        end
        imem_ack = 1'b1;
        imem_rdata = word;
        step();
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        exp_fetch++;
        cur_pc = exp_addr;
        cur_instr = word;
        chk("instr_valid", 32'(instr_valid), 32'd1);
        chk("instr", instr, word);
        chk("req_after_ack", 32'(imem_req), 32'd0);
        chk("pc_in_hold", pc, exp_addr);
    endtask

    task automatic hold_stall(input int n);
        for (int k = 0; k < n; k++) begin
            stall = 1'b1;
            branch = 1'($urandom);
            zero = 1'($urandom);
            jump = 1'($urandom);
            br_imm = 16'($urandom);
            j_target = 26'($urandom);
            imem_ack = 1'($urandom);
            imem_rdata = $urandom;
            step();
            exp_stall++;
            chk("stall_pc", pc, cur_pc);
            chk("stall_instr", instr, cur_instr);
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_req", 32'(imem_req), 32'd0);
        end
        imem_ack = 1'b0;
    endtask

    task automatic release_hold(input logic b, input logic z, input logic j,
                                input logic [15:0] imm, input logic [25:0] jt);
        stall = 1'b0;
        branch = b;
        zero = z;
        jump = j;
        br_imm = imm;
        j_target = jt;
        step();
        branch = 1'($urandom);
        zero = 1'($urandom);
        jump = 1'($urandom);
        stall = 1'($urandom);
        chk("release_valid", 32'(instr_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 26'h0000000, 32'h0000_0010};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 16'hFFFE, 26'h0000000, 32'h0000_000C};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 26'h0000004, 32'h0000_0010};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 16'hFFFE, 26'h0000000, 32'h0000_0014};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 16'hFFF6, 26'h0000000, 32'hFFFF_FFF0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 26'h0000008, 32'hF000_0020};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 26'h0000040, 32'hF000_0100};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 26'h0000008, 32'hF000_0020};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 16'h0001, 26'h0000040, 32'hF000_0028};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 16'h0001, 26'h3FFFFFF, 32'hFFFF_FFFC};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 26'h0000000, 32'h0000_0000};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 16'h7FFF, 26'h0000000, 32'h0002_0000};

        step();
        apply_reset();

        // Sequential walk from reset.
        for (int i = 0; i < 4; i++) begin
            do_fetch(1, 32'(i * 4), $urandom);
            chk("walk_err", 32'(fetch_err), 32'd0);
            if (i < 3) release_hold(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
        end

        // Redirect table.
        for (int i = 0; i < 12; i++) begin
            release_hold(vecs[i].br, vecs[i].z, vecs[i].j, vecs[i].imm, vecs[i].jt);
            do_fetch(i % 3, vecs[i].exp, $urandom);
        end

        // Five stall cycles, then fetch of pc+4 on the very next cycle.
        hold_stall(5);
        nxt = cur_pc + 32'd4;
        release_hold(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
        chk("post_stall_req", 32'(imem_req), 32'd1);
        chk("post_stall_addr", imem_addr, nxt);
        do_fetch(0, nxt, $urandom);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic        rb, rz, rj;
            logic [15:0] rimm;
            logic [25:0] rjt;
            hold_stall($urandom_range(0, 3));
            rb = 1'($urandom);
            rz = 1'($urandom);
            rj = 1'($urandom);
            rimm = 16'($urandom);
            rjt = 26'($urandom);
            nxt = ref_next(cur_pc, rb, rz, rj, rimm, rjt);
            release_hold(rb, rz, rj, rimm, rjt);
            do_fetch($urandom_range(0, 3), nxt, $urandom);
        end
`ifdef FETCH_PERF_EN
        chk("perf_fetch", pf1, 32'(exp_fetch));
        chk("perf_stall", ps1, 32'(exp_stall));
`endif

        // Watchdog: memory never acknowledges.
        nxt = cur_pc + 32'd4;
        release_hold(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
        begin
            int n = 0;
            while (imem_req === 1'b1 && n < 40) begin
                n++;
                step();
            end
            chk("watchdog_cycles", 32'(n), 32'd15);
        end
        for (int k = 0; k < 10; k++) begin
            chk("err_sticky", 32'(fetch_err), 32'd1);
            chk("err_req", 32'(imem_req), 32'd0);
            chk("err_valid", 32'(instr_valid), 32'd0);
            chk("err_pc", pc, nxt);
            imem_ack = 1'($urandom);
            stall = 1'($urandom);
            branch = 1'($urandom);
            jump = 1'($urandom);
            step();
        end
        imem_ack = 1'b0;
        apply_reset();
        do_fetch(0, 32'h0, $urandom);
        chk("err_cleared", 32'(fetch_err), 32'd0);

        // Reset while a fetch is outstanding; the ack after release is dropped.
        release_hold(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
        chk("midfetch_req", 32'(imem_req), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("async_req_drop", 32'(imem_req), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        chk("late_ack_req", 32'(imem_req), 32'd1);
        chk("late_ack_addr", imem_addr, 32'h0);
        chk("late_ack_valid", 32'(instr_valid), 32'd0);
        chk("late_ack_instr", instr, 32'h0);
        do_fetch(0, 32'h0, $urandom);

        // High-region PC: jump, and branch winning over jump.
        apply_reset();
        chk("hi_reset_pc", pc2, 32'h4000_0020);
        do_fetch(0, 32'h0, $urandom);
        chk("hi_valid", 32'(valid2), 32'd1);
        release_hold(1'b0, 1'b0, 1'b1, 16'h0, 26'h0000040);
        chk("hi_jump_req", 32'(req2), 32'd1);
        chk("hi_jump_addr", addr2, 32'h4000_0100);
        do_fetch(0, 32'h0000_0100, $urandom);
        apply_reset();
        do_fetch(0, 32'h0, $urandom);
        release_hold(1'b1, 1'b1, 1'b1, 16'h0001, 26'h0000040);
        chk("hi_branch_wins", addr2, 32'h4000_0028);
        do_fetch(0, 32'h0000_0008, $urandom);
        chk("hi_err", 32'(err2), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
